// File: rtl/midi_pkg.sv
// Shared types and constants for the MIDI note decoder: state encoding,
// status nibbles and the velocity-to-level scaling.
package midi_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_KEY  = 2'd1,
        S_VEL  = 2'd2
    } state_e;

    localparam logic [3:0] MIDI_NOTE_ON  = 4'h9;
    localparam logic [3:0] MIDI_NOTE_OFF = 4'h8;
    localparam logic [7:0] MIDI_RT_MIN   = 8'hF8;

    // Replicating velocity spreads 0..127 across the full 18-bit range (127 -> 0x3FFFF).
    function automatic logic [17:0] vel_to_level(input logic [6:0] vel);
        return {vel, vel, vel[6:3]};
    endfunction

endpackage

// File: rtl/midi_note_decoder.sv
// Monophonic MIDI note-on/note-off parser producing envelope strobes, key and level.
// Optional running status is enabled with `define MIDI_RUNNING_STATUS_EN.
//
// state  | meaning
// S_IDLE | waiting for a status byte (or running-status key)
// S_KEY  | note status seen, waiting for key byte
// S_VEL  | key latched, waiting for velocity byte
module midi_note_decoder
    import midi_pkg::*;
#(
    parameter logic [3:0] CHANNEL = 4'd0
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        note_on,
    output logic        note_off,
    output logic        gate,
    output logic [6:0]  key,
    output logic [17:0] level
);

    state_e      state_q, state_d;
    logic        kind_on_q, kind_on_d;
    logic [6:0]  pend_key_q, pend_key_d;
    logic        rx_ready_q;
    logic        note_on_q, note_on_d;
    logic        note_off_q, note_off_d;
    logic        gate_q, gate_d;
    logic [6:0]  key_q, key_d;
    logic [17:0] level_q, level_d;
    logic        rs_valid;
    logic        byte_acc;
    logic        is_note_status;

`ifdef MIDI_RUNNING_STATUS_EN
    logic rs_valid_q, rs_valid_d;
    assign rs_valid = rs_valid_q;
`else
    assign rs_valid = 1'b0;
`endif

    // Real-time bytes are dropped here so they cannot disturb any state.
    assign byte_acc       = rx_valid && rx_ready_q && (rx_data < MIDI_RT_MIN);
    assign is_note_status = ((rx_data[7:4] == MIDI_NOTE_ON) || (rx_data[7:4] == MIDI_NOTE_OFF))
                            && (rx_data[3:0] == CHANNEL);

    always_comb begin
        state_d    = state_q;
        kind_on_d  = kind_on_q;
        pend_key_d = pend_key_q;
        note_on_d  = 1'b0;
        note_off_d = 1'b0;
        gate_d     = gate_q;
        key_d      = key_q;
        level_d    = level_q;
`ifdef MIDI_RUNNING_STATUS_EN
        rs_valid_d = rs_valid_q;
`endif
        if (byte_acc) begin
            if (rx_data[7]) begin
                if (is_note_status) begin
                    state_d   = S_KEY;
                    kind_on_d = (rx_data[7:4] == MIDI_NOTE_ON);
`ifdef MIDI_RUNNING_STATUS_EN
                    rs_valid_d = 1'b1;
`endif
                end else begin
                    state_d = S_IDLE;
`ifdef MIDI_RUNNING_STATUS_EN
                    rs_valid_d = 1'b0;
`endif
                end
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (rs_valid) begin
                            pend_key_d = rx_data[6:0];
                            state_d    = S_VEL;
                        end
                    end
                    S_KEY: begin
                        pend_key_d = rx_data[6:0];
                        state_d    = S_VEL;
                    end
                    S_VEL: begin
                        state_d = S_IDLE;
                        if (kind_on_q && (rx_data[6:0] != 7'd0)) begin
                            note_on_d = 1'b1;
                            gate_d    = 1'b1;
                            key_d     = pend_key_q;
                            level_d   = vel_to_level(rx_data[6:0]);
                        end else if (gate_q && (pend_key_q == key_q)) begin
                            note_off_d = 1'b1;
                            gate_d     = 1'b0;
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= S_IDLE;
            kind_on_q  <= 1'b0;
            pend_key_q <= 7'd0;
            rx_ready_q <= 1'b0;
            note_on_q  <= 1'b0;
            note_off_q <= 1'b0;
            gate_q     <= 1'b0;
            key_q      <= 7'd0;
            level_q    <= 18'd0;
        end else begin
            state_q    <= state_d;
            kind_on_q  <= kind_on_d;
            pend_key_q <= pend_key_d;
            rx_ready_q <= 1'b1;
            note_on_q  <= note_on_d;
            note_off_q <= note_off_d;
            gate_q     <= gate_d;
            key_q      <= key_d;
            level_q    <= level_d;
        end
    end

`ifdef MIDI_RUNNING_STATUS_EN
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            rs_valid_q <= 1'b0;
        end else begin
            rs_valid_q <= rs_valid_d;
        end
    end
`endif

    assign rx_ready = rx_ready_q;
    assign note_on  = note_on_q;
    assign note_off = note_off_q;
    assign gate     = gate_q;
    assign key      = key_q;
    assign level    = level_q;

endmodule

// File: tb/tb_midi_note_decoder.sv
// Directed self-checking bench for midi_note_decoder (CHANNEL = 0).
module tb_midi_note_decoder;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic        note_on;
    logic        note_off;
    logic        gate;
    logic [6:0]  key;
    logic [17:0] level;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int on_cnt = 0;
    int off_cnt = 0;
    int on_cyc = 0;
    int off_cyc = 0;
    int both_cnt = 0;

    midi_note_decoder #(.CHANNEL(4'd0)) dut (
        .clk      (clk),
        .rst_b    (rst_b),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .note_on  (note_on),
        .note_off (note_off),
        .gate     (gate),
        .key      (key),
        .level    (level)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (note_on) begin
            on_cnt = on_cnt + 1;
            on_cyc = cyc;
        end
        if (note_off) begin
            off_cnt = off_cnt + 1;
            off_cyc = cyc;
        end
        if (note_on && note_off) both_cnt = both_cnt + 1;
    end

    task automatic put(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
    endtask

    // Ends just after the negedge following the last accepted byte.
    task automatic idle();
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #1;
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (rx_ready !== 1'b0) begin errors++; $display("FAIL reset_rx_ready: got %b want 0", rx_ready); end
        checks++;
        if ({note_on, note_off, gate, key, level} !== 27'd0) begin
            errors++; $display("FAIL reset_outputs: got %b%b%b %h %h want all 0", note_on, note_off, gate, key, level);
        end
        rst_b = 1'b1;
        idle();
        checks++;
        if (rx_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b want 1", rx_ready); end
    endtask

    task automatic test_note_on();
        int o;
        o = on_cnt;
        put(8'h90); put(8'h3C); put(8'h7F);
        idle();
        checks++;
        if (note_on !== 1'b1) begin errors++; $display("FAIL on_strobe: got %b want 1", note_on); end
        checks++;
        if ({gate, key, level} !== {1'b1, 7'h3C, 18'h3FFFF}) begin
            errors++; $display("FAIL on_outputs: got gate=%b key=%h level=%h want 1 3c 3ffff", gate, key, level);
        end
        idle();
        checks++;
        if (note_on !== 1'b0 || on_cnt !== o + 1) begin
            errors++; $display("FAIL on_one_cycle: got note_on=%b pulses=%0d want 0 1", note_on, on_cnt - o);
        end
    endtask

    task automatic test_note_off();
        int f;
        f = off_cnt;
        put(8'h80); put(8'h3C); put(8'h00);
        idle();
        checks++;
        if (note_off !== 1'b1 || note_on !== 1'b0) begin
            errors++; $display("FAIL off_strobe: got off=%b on=%b want 1 0", note_off, note_on);
        end
        checks++;
        if ({gate, key, level} !== {1'b0, 7'h3C, 18'h3FFFF}) begin
            errors++; $display("FAIL off_outputs: got gate=%b key=%h level=%h want 0 3c 3ffff", gate, key, level);
        end
        idle();
        checks++;
        if (off_cnt !== f + 1) begin errors++; $display("FAIL off_one_cycle: got %0d pulses want 1", off_cnt - f); end
    endtask

    task automatic test_key_mismatch();
        int o, f;
        o = on_cnt; f = off_cnt;
        put(8'h90); put(8'h40); put(8'h40);
        idle();
        checks++;
        if ({note_on, gate, key, level} !== {1'b1, 1'b1, 7'h40, 18'h20408}) begin
            errors++; $display("FAIL vel64: got on=%b gate=%b key=%h level=%h want 1 1 40 20408", note_on, gate, key, level);
        end
        put(8'h90); put(8'h41); put(8'h00);
        idle(); idle();
        checks++;
        if (on_cnt !== o + 1 || off_cnt !== f) begin
            errors++; $display("FAIL mismatch_strobes: got on=%0d off=%0d want 1 0", on_cnt - o, off_cnt - f);
        end
        checks++;
        if ({gate, key, level} !== {1'b1, 7'h40, 18'h20408}) begin
            errors++; $display("FAIL mismatch_hold: got gate=%b key=%h level=%h want 1 40 20408", gate, key, level);
        end
    endtask

    task automatic test_channel_realtime();
        int o, f;
        o = on_cnt; f = off_cnt;
        put(8'h91); put(8'h3C); put(8'h7F);
        idle(); idle();
        checks++;
        if (on_cnt !== o || off_cnt !== f) begin
            errors++; $display("FAIL other_channel: got on=%0d off=%0d want 0 0", on_cnt - o, off_cnt - f);
        end
        put(8'h90); put(8'h3C); put(8'hF8); put(8'h7F);
        idle();
        checks++;
        if ({note_on, note_off} !== 2'b10) begin
            errors++; $display("FAIL rt_ignored: got on=%b off=%b want 1 0", note_on, note_off);
        end
        checks++;
        if ({gate, key, level} !== {1'b1, 7'h3C, 18'h3FFFF}) begin
            errors++; $display("FAIL retrigger: got gate=%b key=%h level=%h want 1 3c 3ffff", gate, key, level);
        end
        put(8'h90); put(8'h3C); put(8'h01);
        idle();
        checks++;
        if ({note_on, level} !== {1'b1, 18'h00810}) begin
            errors++; $display("FAIL vel1: got on=%b level=%h want 1 00810", note_on, level);
        end
        put(8'h90); put(8'h3C); put(8'h7F);
        idle();
    endtask

    task automatic test_abort();
        int o, f;
        o = on_cnt; f = off_cnt;
        put(8'h90); put(8'h3C); put(8'hB0); put(8'h00);
        put(8'h3C); put(8'h00);
        idle(); idle();
        checks++;
        if (on_cnt !== o || off_cnt !== f) begin
            errors++; $display("FAIL abort_strobes: got on=%0d off=%0d want 0 0", on_cnt - o, off_cnt - f);
        end
        checks++;
        if ({gate, key} !== {1'b1, 7'h3C}) begin
            errors++; $display("FAIL abort_hold: got gate=%b key=%h want 1 3c", gate, key);
        end
    endtask

    task automatic test_running_status();
        int o, f;
        o = on_cnt; f = off_cnt;
        put(8'h90); put(8'h3C); put(8'h7F); put(8'h3C); put(8'h00);
        idle(); idle();
        checks++;
        if (on_cnt !== o + 1) begin errors++; $display("FAIL rs_on: got %0d pulses want 1", on_cnt - o); end
`ifdef MIDI_RUNNING_STATUS_EN
        checks++;
        if (off_cnt !== f + 1 || off_cyc - on_cyc !== 2) begin
            errors++; $display("FAIL rs_off: got pulses=%0d gap=%0d want 1 2", off_cnt - f, off_cyc - on_cyc);
        end
        checks++;
        if (gate !== 1'b0) begin errors++; $display("FAIL rs_gate: got %b want 0", gate); end
`else
        checks++;
        if (off_cnt !== f) begin errors++; $display("FAIL rs_off: got %0d pulses want 0", off_cnt - f); end
        checks++;
        if (gate !== 1'b1) begin errors++; $display("FAIL rs_gate: got %b want 1", gate); end
`endif
    endtask

    task automatic test_reset_mid();
        int o, f;
        put(8'h90); put(8'h3C); put(8'h7F);
        put(8'h90); put(8'h3C);
        @(negedge clk);
        rx_valid = 1'b0;
        #2 rst_b = 1'b0;
        #1;
        checks++;
        if ({rx_ready, note_on, note_off, gate, key, level} !== 28'd0) begin
            errors++; $display("FAIL async_reset: got rdy=%b on=%b off=%b gate=%b key=%h level=%h want all 0",
                               rx_ready, note_on, note_off, gate, key, level);
        end
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        #1;
        checks++;
        if (rx_ready !== 1'b0) begin errors++; $display("FAIL ready_before_edge: got %b want 0", rx_ready); end
        o = on_cnt; f = off_cnt;
        put(8'h7F);
        idle(); idle();
        checks++;
        if (on_cnt !== o || off_cnt !== f || gate !== 1'b0 || key !== 7'h00) begin
            errors++; $display("FAIL stale_after_reset: got on=%0d off=%0d gate=%b key=%h want 0 0 0 00",
                               on_cnt - o, off_cnt - f, gate, key);
        end
        checks++;
        if (rx_ready !== 1'b1) begin errors++; $display("FAIL ready_after_release: got %b want 1", rx_ready); end
    endtask

    initial begin
        test_reset();
        test_note_on();
        test_note_off();
        test_key_mismatch();
        test_channel_realtime();
        test_abort();
        test_running_status();
        test_reset_mid();
        checks++;
        if (both_cnt !== 0) begin errors++; $display("FAIL exclusive_strobes: got %0d overlaps want 0", both_cnt); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/midi_note_decoder.md
# midi_note_decoder

Parses a serial MIDI byte stream (one byte per handshake from the UART receiver) and produces the single-cycle `note_on` / `note_off` strobes that drive `envelope_generator`. Alongside the strobes it outputs the held key number and an 18-bit peak level scaled from velocity, which feeds the generator's attack target. The block is monophonic: it tracks one held note, and only that note's release generates `note_off`.

## Interface
- `CHANNEL`, default 4'd0: the MIDI channel (0–15) this decoder listens to.
- `clk` input, 1 bit: system clock; all state updates on the rising edge.
- `rst_b` input, 1 bit: asynchronous, active-low reset.
- `rx_valid` input, 1 bit: `rx_data` holds a byte.
- `rx_data` input, 8 bits: MIDI byte.
- `rx_ready` output, 1 bit: decoder accepts a byte. It is 0 in reset and 1 constantly after reset. A byte transfers when `rx_valid && rx_ready`.
- `note_on` output, 1 bit: one-cycle strobe, a new note has started.
- `note_off` output, 1 bit: one-cycle strobe, the held note has been released.
- `gate` output, 1 bit: a note is currently held.
- `key` output, 7 bits: key number of the last note-on.
- `level` output, 18 bits: peak level derived from that note's velocity.

## Operation
- Reset values:
  - `note_on`, `note_off`, `gate`, `key`, `level` = 0.
  - `rx_ready` = 0.
  - State = `S_IDLE`.
  - Running-status register is invalid.
- State machine: `S_IDLE` → `S_KEY` → `S_VEL`. It advances only on an accepted byte.
- Real-time bytes (0xF8–0xFF): ignored in every state. State, the partially collected key and running status are all unchanged.
- Accepted status byte (bit 7 = 1, not real-time):
  - 0x9n or 0x8n with n == `CHANNEL`: latch the kind (ON/OFF), go to `S_KEY`, and mark running status valid.
  - Any other status byte: go to `S_IDLE` and invalidate running status.
  - A status byte arriving in `S_KEY` or `S_VEL` aborts the partial message. No strobe is emitted.
- Data byte in `S_IDLE`: taken as a key if running status is valid (see Configuration); otherwise discarded.
- Data byte in `S_KEY`: latch it as the pending key and go to `S_VEL`.
- Data byte in `S_VEL`: evaluate the message, then go to `S_IDLE`.
  - ON with velocity > 0:
    - Emit `note_on`, set `gate` = 1.
    - Set `key` = pending key.
    - Set `level` = {vel, vel, vel[6:3]}, i.e. (vel<<11)|(vel<<4)|(vel>>3). 127 → 0x3FFFF, 64 → 0x20408, 1 → 0x00810.
    - A note-on while `gate` = 1 (any key) retriggers: `note_on` strobes again and `key`/`level` are replaced. No `note_off` is emitted.
  - OFF, or ON with velocity 0:
    - If `gate` = 1 and pending key == `key`: emit `note_off`, set `gate` = 0. `key` and `level` hold.
    - Otherwise: no strobe, nothing changes.
  - The velocity of an OFF message is ignored.
- Reset mid-message: the pending key and kind are discarded and no strobe is emitted. Outputs take their reset values asynchronously.

## Timing
- A strobe asserts in the cycle after the velocity byte is accepted and lasts exactly one cycle.
- `gate`, `key` and `level` update on the same edge as the strobe.
- `note_on` and `note_off` are never both high.
- Back-to-back bytes (`rx_valid` high every cycle) are accepted at full rate, so consecutive messages can produce strobes 3 cycles apart (2 cycles apart with running status).
- `rx_ready` rises on the first clock edge after `rst_b` deasserts.
- No combinational path from the `rx_*` inputs to any output.

## Configuration
- `MIDI_RUNNING_STATUS_EN` defined:
  - After a completed message, a data byte in `S_IDLE` is treated as the key of a new message of the latched kind.
  - Running status stays valid until a non-matching status byte or reset.
- `MIDI_RUNNING_STATUS_EN` undefined:
  - Running status is never valid; data bytes in `S_IDLE` are always discarded.
  - The running-status register is not implemented.

## Structure
- Shared package `midi_pkg` holds:
  - State enum: `S_IDLE`, `S_KEY`, `S_VEL`.
  - Status constants: `MIDI_NOTE_ON` = 4'h9, `MIDI_NOTE_OFF` = 4'h8, `MIDI_RT_MIN` = 8'hF8.
  - Function `vel_to_level` (7-bit velocity → 18-bit level).
- Single module; no sub-module is warranted.

## Test plan
1. Stream 0x90 0x3C 0x7F → `note_on` pulse one cycle after the last byte; `gate` = 1, `key` = 0x3C, `level` = 0x3FFFF.
2. Then 0x80 0x3C 0x00 → one `note_off` pulse; `gate` = 0; `key` stays 0x3C.
3. 0x90 0x40 0x40, then 0x90 0x41 0x00 → only `note_on` (`level` = 0x20408); no `note_off`, because the key mismatches; `gate` stays 1.
4. 0x91 0x3C 0x7F with `CHANNEL` = 0 → no strobes; 0x90 0x3C 0xF8 0x7F → `note_on` (the real-time byte is ignored).
5. With the macro: 0x90 0x3C 0x7F 0x3C 0x00 → `note_on`, then `note_off` 2 cycles later. Without the macro: `note_on` only.
6. Assert `rst_b` low after 0x90 0x3C → all outputs 0 immediately; after release, 0x7F alone → no strobe.
